// File: rtl/mux4way16_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4-way mux datapath.
// One requester (W/X/Y/Z) owns the channel for a bounded burst; the selected
// word is registered into a single-entry valid/ready output stage.
module mux4way16_arbiter #(
  parameter int MAX_BURST = 4,  // beats per grant, 1..15
  parameter int WIDTH     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] W,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [WIDTH-1:0] Z,
  input  logic [3:0]       req,
  output logic [3:0]       gnt,
  output logic [3:0]       ack,
  output logic [1:0]       s,
  output logic [WIDTH-1:0] OUT,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // beat_cnt value at which the current burst ends
  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_ptr;
  logic [1:0]       w_ptr_next;
  logic [3:0]       r_beat_cnt;
  logic [3:0]       w_beat_cnt_next;
  logic [3:0]       r_gnt;
  logic [3:0]       w_gnt_next;
  logic [1:0]       r_s;
  logic [1:0]       w_s_next;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;

  logic             w_space;
  logic             w_load;
  logic [3:0]       w_req_rot;
  logic             w_found;
  logic [1:0]       w_winner;
  logic [WIDTH-1:0] w_sel_data;

  // Output stage can take a word if empty or if it is being drained now
  assign w_space = !r_out_valid || out_ready;
  assign w_load  = (r_state == ST_BUSY) && req[r_s] && w_space;

  // Rotate requests so that bit 0 is the requester at the round-robin pointer,
  // and derive the per-requester accept strobe from the one-hot grant.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_req_rot[gi] = req[r_ptr + 2'(gi)];
    assign ack[gi]       = r_gnt[gi] & w_load;
  end

  // Pick the first requester at or after the pointer (lowest rotated index wins)
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        w_found  = 1'b1;
        w_winner = r_ptr + 2'(i);
      end
    end
  end

  // Datapath mux driven by the registered owner select
  always_comb begin
    w_sel_data = W;
    case (r_s)
      2'd0:    w_sel_data = W;
      2'd1:    w_sel_data = X;
      2'd2:    w_sel_data = Y;
      default: w_sel_data = Z;
    endcase
  end

  // Next-state logic: grant in IDLE, count beats / release in BUSY, hold on stall
  always_comb begin
    w_state_next    = r_state;
    w_ptr_next      = r_ptr;
    w_beat_cnt_next = r_beat_cnt;
    w_gnt_next      = r_gnt;
    w_s_next        = r_s;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_next    = ST_BUSY;
          w_gnt_next      = 4'b0001 << w_winner;
          w_s_next        = w_winner;
          w_beat_cnt_next = 4'd0;
        end
      end
      ST_BUSY: begin
        if (!req[r_s]) begin
          // owner withdrew: release without transferring a beat
          w_state_next    = ST_IDLE;
          w_gnt_next      = 4'b0000;
          w_ptr_next      = r_s + 2'd1;
          w_beat_cnt_next = 4'd0;
        end else if (w_load) begin
          if (r_beat_cnt == LAST_BEAT) begin
            w_state_next    = ST_IDLE;
            w_gnt_next      = 4'b0000;
            w_ptr_next      = r_s + 2'd1;
            w_beat_cnt_next = 4'd0;
          end else begin
            w_beat_cnt_next = r_beat_cnt + 4'd1;
          end
        end
        // requesting but no space: everything holds
      end
      default: begin
        w_state_next = ST_IDLE;
        w_gnt_next   = 4'b0000;
      end
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 2'd0;
      r_beat_cnt <= 4'd0;
      r_gnt      <= 4'b0000;
      r_s        <= 2'd0;
    end else begin
      r_state    <= w_state_next;
      r_ptr      <= w_ptr_next;
      r_beat_cnt <= w_beat_cnt_next;
      r_gnt      <= w_gnt_next;
      r_s        <= w_s_next;
    end
  end

  // Single-entry output register: load wins over consume, so both in one
  // cycle keeps out_valid high and sustains one word per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out       <= w_sel_data;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign gnt       = r_gnt;
  assign s         = r_s;
  assign OUT       = r_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux4way16_arbiter.sv
// Self-checking bench for mux4way16_arbiter: directed cycle tables for
// grant/ack plus a scoreboard queue of expected output words.
module tb_mux4way16_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] W, X, Y, Z;
  logic [3:0]  req;
  logic        out_ready;

  logic [3:0]  gnt_b4, ack_b4, gnt_b2, ack_b2;
  logic [1:0]  s_b4, s_b2;
  logic [15:0] out_b4, out_b2;
  logic        valid_b4, valid_b2;

  // which instance is being observed (MAX_BURST=2 instance when set)
  logic        use_b2;
  logic [3:0]  o_gnt, o_ack;
  logic [1:0]  o_s;
  logic [15:0] o_out;
  logic        o_valid;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [15:0] sb_q[$];
  int          k_drv[4];
  int          k_exp[4];
  logic [3:0]  ack_prev;
  logic [15:0] ybase;
  logic [15:0] zword;

  always #5 clk = ~clk;

  // observe the selected instance
  always_comb begin
    o_gnt   = use_b2 ? gnt_b2   : gnt_b4;
    o_ack   = use_b2 ? ack_b2   : ack_b4;
    o_s     = use_b2 ? s_b2     : s_b4;
    o_out   = use_b2 ? out_b2   : out_b4;
    o_valid = use_b2 ? valid_b2 : valid_b4;
  end

  mux4way16_arbiter #(.MAX_BURST(4), .WIDTH(16)) u_dut_b4 (
    .clk(clk), .rst(rst), .W(W), .X(X), .Y(Y), .Z(Z), .req(req),
    .gnt(gnt_b4), .ack(ack_b4), .s(s_b4), .OUT(out_b4),
    .out_valid(valid_b4), .out_ready(out_ready)
  );

  mux4way16_arbiter #(.MAX_BURST(2), .WIDTH(16)) u_dut_b2 (
    .clk(clk), .rst(rst), .W(W), .X(X), .Y(Y), .Z(Z), .req(req),
    .gnt(gnt_b2), .ack(ack_b2), .s(s_b2), .OUT(out_b2),
    .out_valid(valid_b2), .out_ready(out_ready)
  );

  // k-th word offered by requester i
  function automatic logic [15:0] data_of(input int i, input int k);
    logic [15:0] base;
    case (i)
      0:       base = 16'hA000;
      1:       base = 16'h0000;
      2:       base = 16'hC000;
      default: base = 16'hD000;
    endcase
    return base + 16'(2 * (k + 1));
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input int i, input int n);
    for (int b = 0; b < n; b++) begin
      sb_q.push_back(data_of(i, k_exp[i]));
      k_exp[i]++;
    end
  endtask

  // One clock cycle: drive after the rising edge, check at the falling edge
  task automatic run_cycle(input logic rst_v, input logic [3:0] req_v, input logic rdy_v,
                           input logic chk, input logic [3:0] exp_gnt,
                           input logic [3:0] exp_ack, input string tag);
    logic [15:0] exp_word;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (ack_prev[i] === 1'b1) k_drv[i]++;
    end
    W = data_of(0, k_drv[0]);
    X = data_of(1, k_drv[1]);
    Y = data_of(2, k_drv[2]);
    Z = data_of(3, k_drv[3]);
    rst       = rst_v;
    req       = req_v;
    out_ready = rdy_v;
    @(negedge clk);
    if (chk) begin
      check_eq({tag, ".gnt"}, 16'(o_gnt), 16'(exp_gnt));
      check_eq({tag, ".ack"}, 16'(o_ack), 16'(exp_ack));
      if (o_valid === 1'b1 && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq({tag, ".unexpected_word"}, 16'(sb_q.size()), 16'd1);
        end else begin
          exp_word = sb_q.pop_front();
          $display("[%0t] %s: word %h expected %h", $time, tag, o_out, exp_word);
          check_eq({tag, ".out"}, o_out, exp_word);
        end
      end
    end
    ack_prev = o_ack;
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; out_ready = 1'b1;
    W = '0; X = '0; Y = '0; Z = '0;
    use_b2 = 1'b0; ack_prev = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      k_drv[i] = 0;
      k_exp[i] = 0;
    end

    // 1. reset with all requests high, then first grant goes to W
    run_cycle(1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0000, "rst0");
    run_cycle(1'b1, 4'b1111, 1'b1, 1'b1, 4'b0000, 4'b0000, "rst1");
    check_eq("rst.s", 16'(o_s), 16'd0);
    check_eq("rst.out", o_out, 16'h0000);
    check_eq("rst.valid", 16'(o_valid), 16'd0);
    run_cycle(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0000, 4'b0000, "t1.idle");
    run_cycle(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0001, 4'b0000, "t1.first");

    // 2. single requester X: words 2,4,6 then drop request
    run_cycle(1'b0, 4'b0010, 1'b1, 1'b1, 4'b0000, 4'b0000, "t2.idle");
    push_exp(1, 3);
    run_cycle(1'b0, 4'b0010, 1'b1, 1'b1, 4'b0010, 4'b0010, "t2.b0");
    check_eq("t2.s", 16'(o_s), 16'd1);
    run_cycle(1'b0, 4'b0010, 1'b1, 1'b1, 4'b0010, 4'b0010, "t2.b1");
    run_cycle(1'b0, 4'b0010, 1'b1, 1'b1, 4'b0010, 4'b0010, "t2.b2");
    run_cycle(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0010, 4'b0000, "t2.drop");
    // pointer now 2: with all requesting, Y must win next
    run_cycle(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0000, 4'b0000, "t2.idle2");
    check_eq("t2.drained", 16'(sb_q.size()), 16'd0);

    // 4. backpressure while Y owns: three stall cycles, then full burst of 4
    ybase = data_of(2, k_exp[2]);
    push_exp(2, 4);
    run_cycle(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0100, 4'b0100, "t4.b0");
    for (int c = 0; c < 3; c++) begin
      run_cycle(1'b0, 4'b1111, 1'b0, 1'b1, 4'b0100, 4'b0000, "t4.stall");
      check_eq("t4.hold_out", o_out, ybase);
      check_eq("t4.hold_valid", 16'(o_valid), 16'd1);
    end
    run_cycle(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0100, 4'b0100, "t4.b1");
    run_cycle(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0100, 4'b0100, "t4.b2");
    run_cycle(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0100, 4'b0100, "t4.b3");
    // pointer now 3; only Y requests so Y wins again
    run_cycle(1'b0, 4'b0100, 1'b1, 1'b1, 4'b0000, 4'b0000, "t4.idle");
    check_eq("t4.drained", 16'(sb_q.size()), 16'd0);

    // 5. early release: Y drops after one beat, Z takes over
    push_exp(2, 1);
    run_cycle(1'b0, 4'b1100, 1'b1, 1'b1, 4'b0100, 4'b0100, "t5.b0");
    check_eq("t5.s_y", 16'(o_s), 16'd2);
    run_cycle(1'b0, 4'b1000, 1'b1, 1'b1, 4'b0100, 4'b0000, "t5.drop");
    run_cycle(1'b0, 4'b1000, 1'b1, 1'b1, 4'b0000, 4'b0000, "t5.idle");
    run_cycle(1'b0, 4'b1000, 1'b1, 1'b1, 4'b1000, 4'b1000, "t5.z");
    check_eq("t5.s_z", 16'(o_s), 16'd3);
    check_eq("t5.drained", 16'(sb_q.size()), 16'd0);

    // 6. reset mid-burst with a held word
    zword = data_of(3, k_exp[3]);
    k_exp[3]++;
    run_cycle(1'b1, 4'b1111, 1'b0, 1'b1, 4'b1000, 4'b0000, "t6.hold");
    check_eq("t6.held_out", o_out, zword);
    check_eq("t6.held_valid", 16'(o_valid), 16'd1);
    run_cycle(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0000, 4'b0000, "t6.rst");
    check_eq("t6.s", 16'(o_s), 16'd0);
    check_eq("t6.out", o_out, 16'h0000);
    check_eq("t6.valid", 16'(o_valid), 16'd0);
    run_cycle(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0001, 4'b0000, "t6.first");
    run_cycle(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, "t6.idle");

    // 3. full contention on the MAX_BURST=2 instance: W,X,Y,Z,W
    use_b2 = 1'b1;
    run_cycle(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, "t3.rst0");
    run_cycle(1'b1, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, "t3.rst1");
    push_exp(0, 2);
    push_exp(1, 2);
    push_exp(2, 2);
    push_exp(3, 2);
    push_exp(0, 2);
    for (int n = 0; n < 5; n++) begin
      run_cycle(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0000, 4'b0000, "t3.gap");
      for (int b = 0; b < 2; b++) begin
        run_cycle(1'b0, 4'b1111, 1'b1, 1'b1, 4'(1 << (n % 4)), 4'(1 << (n % 4)), "t3.beat");
      end
    end
    run_cycle(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, "t3.tail");
    check_eq("t3.drained", 16'(sb_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mux4way16_arbiter.md
Name: mux4way16_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 4-way 16-bit multiplexer datapath.
- Four requesters (W, X, Y, Z) compete for one 16-bit output channel.
- The block grants one requester at a time for a bounded burst and drives the mux select `s`.
- The selected word is registered into a single-entry output stage with valid/ready handshake toward the downstream consumer.

Parameters:
- MAX_BURST, 4: maximum beats one owner may transfer per grant; legal range 1..15.
- WIDTH, 16: data width of each requester and of OUT.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- W  input  WIDTH  requester 0 data.
- X  input  WIDTH  requester 1 data.
- Y  input  WIDTH  requester 2 data.
- Z  input  WIDTH  requester 3 data.
- req  input  4  per-requester request; bit0=W … bit3=Z.
- gnt  output  4  registered one-hot grant; all zero when idle.
- ack  output  4  combinational per-requester beat-accept strobe.
- s  output  2  registered mux select; encodes current owner.
- OUT  output  WIDTH  registered output data.
- out_valid  output  1  OUT holds an unconsumed word.
- out_ready  input  1  downstream accepts OUT this cycle.

Behaviour:
- Reset values:
  - gnt=0, s=2'b00, OUT=0, out_valid=0, ack=0.
  - Internal: ptr=0, beat_cnt=0, state=IDLE.
  - Reset mid-operation discards any held word and any burst in progress.
- Definitions:
  - space = !out_valid | out_ready.
  - load = state==BUSY & req[s] & space.
  - ack[i] = gnt[i] & load. At most one ack bit is set in any cycle.
- States:
  - IDLE: if req!=0, select the first set bit scanning ptr, ptr+1, … mod 4. Next cycle: state=BUSY, gnt=onehot(winner), s=winner, beat_cnt=0. If req==0, stay in IDLE.
  - BUSY, load with beat_cnt==MAX_BURST-1: burst complete. Next cycle: IDLE, gnt=0, ptr=s+1 mod 4, beat_cnt=0.
  - BUSY, load with beat_cnt<MAX_BURST-1: beat_cnt+1; stay in BUSY.
  - BUSY, req[s]==0: release without a beat. Next cycle: IDLE, gnt=0, ptr=s+1 mod 4.
  - BUSY, req[s]==1 & !space: stall; hold all state, no ack, beat_cnt unchanged.
- s holds its last value while in IDLE. It is only meaningful when gnt!=0.
- Output stage:
  - On load: OUT <= selected input (W/X/Y/Z by s), out_valid <= 1.
  - Else if out_ready: out_valid <= 0; OUT holds its value.
  - While out_valid & !out_ready, OUT is stable.
  - Load and consume in the same cycle are allowed, giving a throughput of 1 word/cycle.
- Latency:
  - req rising in IDLE at edge t → gnt/s valid after edge t+1.
  - First ack in cycle t+1 (if space) → out_valid after edge t+2.
- Arbitration bubble: exactly one IDLE cycle between consecutive owners.
- Fairness: ptr advances past the last owner, so any continuously requesting requester is granted within 3 other grants.
- Requester data must be stable in a cycle where its ack is high; it is sampled on that edge.
- Requests that drop while not granted have no effect.
- MAX_BURST=1 gives strict per-beat round robin, with one bubble per beat.

Test Plan:
1. Reset: drive rst=1 for 2 cycles with req=4'b1111 → gnt=0, s=0, OUT=0, out_valid=0, ack=0. First grant after release of reset is W (gnt=0001).
2. Single requester: req=0010, X=2,4,6 on successive ack cycles, out_ready=1, MAX_BURST=4.
   - gnt=0010 and s=01 one cycle after req.
   - OUT=2,4,6 on consecutive cycles.
   - X drops req after the third beat → gnt=0 the next cycle, ptr=2.
3. Full contention: req=1111 held, out_ready=1, MAX_BURST=2 → grant order W,X,Y,Z,W, with 2 acks per owner and one idle cycle between owners.
4. Backpressure: Y owns, out_valid=1, out_ready=0 for 3 cycles.
   - OUT is unchanged and ack=0 throughout.
   - beat_cnt is frozen.
   - After out_ready=1, transfers resume with no word lost or duplicated.
5. Early release: Y owns, req=1100, Y drops req after 1 beat → IDLE, then Z granted (gnt=1000, s=11).
6. Reset mid-burst: assert rst while BUSY with out_valid=1 → next cycle all outputs are at reset values; with req=1111 the next grant is W.
